// File: rtl/pc_call_stack_if.sv
// Bus between the controller and the program-counter / return-stack block.
// The master side issues commands (load, increment, call, ret) with a target
// address; the slave side returns the current address, stack occupancy and
// sticky error flags.
interface pc_call_stack_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned SP_WIDTH    = $clog2(STACK_DEPTH + 1)
);
  logic                  load;
  logic                  increment;
  logic                  call;
  logic                  ret;
  logic [ADDR_WIDTH-1:0] load_data;

  logic [ADDR_WIDTH-1:0] counter;
  logic [SP_WIDTH-1:0]   sp;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  out_of_range;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output load, increment, call, ret, load_data,
    input  counter, sp, stack_full, stack_empty, out_of_range, overflow_err, underflow_err
  );

  modport slave (
    input  load, increment, call, ret, load_data,
    output counter, sp, stack_full, stack_empty, out_of_range, overflow_err, underflow_err
  );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with an integrated hardware return-address stack.
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   a_reset  - asynchronous active-high reset
//   reset    - synchronous clear, same effect as a_reset
//   bus      - slave side of pc_call_stack_if: commands load/increment/call/ret
//              with load_data in; counter, sp, stack_full/empty and sticky
//              out_of_range/overflow_err/underflow_err out.
// Command priority in a cycle: reset > call > ret > load > increment.
module pc_call_stack #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
  input logic              clk,
  input logic              a_reset,
  input logic              reset,
  pc_call_stack_if.slave   bus
);

  // Stack storage is rounded up to a power of two so slot indices are exact-width.
  localparam int unsigned IdxWidth   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned StackSlots = 1 << IdxWidth;
  localparam logic [SP_WIDTH-1:0] SpFull = SP_WIDTH'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic [SP_WIDTH-1:0]   sp_q, sp_d;
  logic                  oor_q, oor_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [ADDR_WIDTH-1:0] stack_q [StackSlots];

  logic                  full, empty;
  logic [ADDR_WIDTH:0]   inc_full;
  logic [ADDR_WIDTH-1:0] inc_addr;
  logic                  inc_wrap;
  logic [SP_WIDTH-1:0]   sp_dec;
  logic [IdxWidth-1:0]   push_idx, pop_idx;
  logic                  push_en;

  assign full     = (sp_q == SpFull);
  assign empty    = (sp_q == '0);
  assign inc_full = {1'b0, counter_q} + (ADDR_WIDTH + 1)'(1);
  assign inc_addr = inc_full[ADDR_WIDTH-1:0];
  assign inc_wrap = inc_full[ADDR_WIDTH];
  assign sp_dec   = sp_q - SP_WIDTH'(1);
  assign push_idx = sp_q[IdxWidth-1:0];
  assign pop_idx  = sp_dec[IdxWidth-1:0];

  always_comb begin
    counter_d = counter_q;
    sp_d      = sp_q;
    oor_d     = oor_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    push_en   = 1'b0;
    if (reset) begin
      counter_d = '0;
      sp_d      = '0;
      oor_d     = 1'b0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else if (bus.call) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push_en   = 1'b1;
        sp_d      = sp_q + SP_WIDTH'(1);
        counter_d = bus.load_data;
        // Return address wraps to 0 when calling from the last address.
        if (inc_wrap) oor_d = 1'b1;
      end
    end else if (bus.ret) begin
      if (empty) begin
        udf_d = 1'b1;
      end else begin
        counter_d = stack_q[pop_idx];
        sp_d      = sp_dec;
      end
    end else if (bus.load) begin
      counter_d = bus.load_data;
    end else if (bus.increment) begin
      counter_d = inc_addr;
      if (inc_wrap) oor_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      counter_q <= '0;
      sp_q      <= '0;
      oor_q     <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      sp_q      <= sp_d;
      oor_q     <= oor_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= inc_addr;
  end

  assign bus.counter       = counter_q;
  assign bus.sp            = sp_q;
  assign bus.stack_full    = full;
  assign bus.stack_empty   = empty;
  assign bus.out_of_range  = oor_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack: reset, nested calls, overflow, underflow,
// command priority, address wrap and both reset flavours.
module tb_pc_call_stack;

  logic clk = 1'b0;
  logic a_reset = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  pc_call_stack_if #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) bus ();

  pc_call_stack #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk     (clk),
    .a_reset (a_reset),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one command for one clock edge, then sample 1 time unit after the edge.
  task automatic cmd(input logic c_call, input logic c_ret, input logic c_load,
                     input logic c_inc, input logic [7:0] data);
    bus.call      = c_call;
    bus.ret       = c_ret;
    bus.load      = c_load;
    bus.increment = c_inc;
    bus.load_data = data;
    @(posedge clk);
    #1;
    bus.call      = 1'b0;
    bus.ret       = 1'b0;
    bus.load      = 1'b0;
    bus.increment = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] cnt, input logic [2:0] sp);
    check({tag, ".counter"}, 32'(bus.counter), 32'(cnt));
    check({tag, ".sp"}, 32'(bus.sp), 32'(sp));
  endtask

  task automatic check_flags(input string tag, input logic oor, input logic ovf, input logic udf);
    check({tag, ".oor"}, 32'(bus.out_of_range), 32'(oor));
    check({tag, ".ovf"}, 32'(bus.overflow_err), 32'(ovf));
    check({tag, ".udf"}, 32'(bus.underflow_err), 32'(udf));
  endtask

  initial begin
    bus.call = 1'b0; bus.ret = 1'b0; bus.load = 1'b0; bus.increment = 1'b0;
    bus.load_data = '0;

    // Reset state
    #1 a_reset = 1'b1;
    #2;
    check_state("rst", 8'h00, 3'd0);
    check("rst.empty", 32'(bus.stack_empty), 32'd1);
    check("rst.full", 32'(bus.stack_full), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 a_reset = 1'b0;

    // Increment x3
    for (int i = 0; i < 3; i++) cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_state("inc3", 8'h03, 3'd0);
    check("inc3.empty", 32'(bus.stack_empty), 32'd1);
    check_flags("inc3", 1'b0, 1'b0, 1'b0);

    // Nested calls
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
    check_state("ld10", 8'h10, 3'd0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
    check_state("call40", 8'h40, 3'd1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    check_state("call80", 8'h80, 3'd2);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("ret1", 8'h41, 3'd1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("ret2", 8'h11, 3'd0);

    // Overflow: pushes 0x12, 0x21, 0x21, 0x21; fifth call rejected
    for (int i = 0; i < 4; i++) cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
    check_state("call4", 8'h20, 3'd4);
    check("call4.full", 32'(bus.stack_full), 32'd1);
    check("call4.ovf", 32'(bus.overflow_err), 32'd0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
    check_state("call5", 8'h20, 3'd4);
    check("call5.ovf", 32'(bus.overflow_err), 32'd1);
    for (int i = 0; i < 3; i++) cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("ovret3", 8'h21, 3'd1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("ovret4", 8'h12, 3'd0);
    check("ovret4.empty", 32'(bus.stack_empty), 32'd1);
    check_flags("ovret4", 1'b0, 1'b1, 1'b0);

    // Underflow with increment also high: ret wins, counter holds
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check_state("udf", 8'h12, 3'd0);
    check("udf.flag", 32'(bus.underflow_err), 32'd1);
    // call+ret+load together: call wins, pushes 0x13
    cmd(1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
    check_state("prio", 8'h33, 3'd1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("prioret", 8'h13, 3'd0);

    // Wrap
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    check_state("ldff", 8'hFF, 3'd0);
    check("ldff.oor", 32'(bus.out_of_range), 32'd0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_state("wrap", 8'h00, 3'd0);
    check("wrap.oor", 32'(bus.out_of_range), 32'd1);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    check_state("callwrap", 8'h05, 3'd1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("retwrap", 8'h00, 3'd0);
    check_flags("retwrap", 1'b1, 1'b1, 1'b1);

    // Async reset mid-cycle with sp=3
    for (int i = 0; i < 3; i++) cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h50);
    check_state("pre_arst", 8'h50, 3'd3);
    #3 a_reset = 1'b1;
    #1;
    check_state("arst", 8'h00, 3'd0);
    check("arst.empty", 32'(bus.stack_empty), 32'd1);
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    #1 a_reset = 1'b0;

    // Stack discarded: ret now underflows
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_state("postarst", 8'h00, 3'd0);
    check("postarst.udf", 32'(bus.underflow_err), 32'd1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h60);
    check_state("call60", 8'h60, 3'd1);

    // Sync reset coincident with call: reset wins
    reset = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    reset = 1'b0;
    check_state("srst", 8'h00, 3'd0);
    check("srst.empty", 32'(bus.stack_empty), 32'd1);
    check_flags("srst", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
